// File: rtl/apb_master_arb.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ requesters.
// Each accepted command runs SETUP/ACCESS and returns a one-cycle response pulse.
module apb_master_arb #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                             pclk,
  input  logic                             preset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  input  logic [DATA_WIDTH-1:0]            prdata,
  input  logic                             pready
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       cur_q, cur_d;
  logic [IdxW-1:0]       last_grant_q, last_grant_d;
  logic [CntW-1:0]       wait_q, wait_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  logic                  found;
  logic [IdxW-1:0]       winner;
  logic [IdxW-1:0]       cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts just after the last grant so the previous winner ranks lowest.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IdxW'((32'(last_grant_q) + off) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && found) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    last_grant_d = last_grant_q;
    wait_d       = wait_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d      = StSetup;
          cur_d        = winner;
          last_grant_d = winner;
          pwrite_d     = req_write[winner];
          paddr_d      = addr_arr[winner];
          pwdata_d     = wdata_arr[winner];
        end
      end
      StSetup: begin
        wait_d  = '0;
        state_d = StAccess;
      end
      StAccess: begin
        if (pready) begin
          state_d            = StIdle;
          rsp_valid_d[cur_q] = 1'b1;
          rsp_rdata_d        = pwrite_q ? '0 : prdata;
          rsp_err_d          = 1'b0;
        end else if (TIMEOUT != 0 && wait_q == CntW'(TIMEOUT - 1)) begin
          state_d            = StIdle;
          rsp_valid_d[cur_q] = 1'b1;
          rsp_rdata_d        = '0;
          rsp_err_d          = 1'b1;
        end else if (wait_q != '1) begin
          wait_d = wait_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q      <= StIdle;
      cur_q        <= '0;
      last_grant_q <= IdxW'(NUM_REQ - 1);
      wait_q       <= '0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      last_grant_q <= last_grant_d;
      wait_q       <= wait_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign psel      = (state_q != StIdle);
  assign penable   = (state_q == StAccess);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: single write, waited read, contention, timeout,
// and reset in the middle of an ACCESS phase.
module tb_apb_master_arb;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 2;
  localparam int unsigned TO = 16;

  logic             pclk = 1'b0;
  logic             preset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic             psel, penable, pwrite;
  logic [AW-1:0]    paddr;
  logic [DW-1:0]    pwdata;
  logic [DW-1:0]    prdata;
  logic             pready;

  int errors = 0;
  int checks = 0;

  apb_master_arb #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .TIMEOUT    (TO)
  ) dut (
    .pclk      (pclk),
    .preset    (preset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready)
  );

  always #5 pclk = ~pclk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    #1;
    checks++;
    if ({psel, penable, pwrite, rsp_err} !== 4'b0000 || paddr !== '0 || pwdata !== '0 ||
        rsp_valid !== '0 || rsp_rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h rsp_valid=%b rdata=%h err=%b, want all 0",
               psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err);
    end
    step();
    step();
    preset = 1'b0;
    step();
    checks++;
    if (psel !== 1'b0 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: psel=%b req_ready=%b, want 0/00", psel, req_ready);
    end
  endtask

  task automatic test_single_write();
    pready = 1'b1;
    req_valid = 2'b01;
    req_write = 2'b01;
    req_addr[31:0] = 32'h10;
    req_wdata[31:0] = 32'hA5A5_0001;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL wr_ready: got %b want 01", req_ready);
    end
    step();  // cycle 1: SETUP, requester still valid but must not be re-accepted
    checks++;
    if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 32'h10 || pwdata !== 32'hA5A5_0001 ||
        pwrite !== 1'b1 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL wr_setup: psel=%b penable=%b paddr=%h pwdata=%h pwrite=%b ready=%b",
               psel, penable, paddr, pwdata, pwrite, req_ready);
    end
    req_valid = 2'b00;
    step();  // cycle 2: ACCESS
    checks++;
    if (psel !== 1'b1 || penable !== 1'b1 || paddr !== 32'h10 || pwdata !== 32'hA5A5_0001 ||
        rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL wr_access: psel=%b penable=%b paddr=%h pwdata=%h rsp_valid=%b",
               psel, penable, paddr, pwdata, rsp_valid);
    end
    step();  // cycle 3: response
    checks++;
    if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || psel !== 1'b0) begin
      errors++;
      $display("FAIL wr_rsp: rsp_valid=%b err=%b psel=%b, want 01/0/0", rsp_valid, rsp_err, psel);
    end
    step();
    checks++;
    if (rsp_valid !== 2'b00 || paddr !== 32'h10) begin
      errors++;
      $display("FAIL wr_after: rsp_valid=%b paddr=%h, want 00/10", rsp_valid, paddr);
    end
  endtask

  task automatic test_read_wait();
    pready = 1'b0;
    req_valid = 2'b10;
    req_write = 2'b00;
    req_addr[63:32] = 32'h20;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL rd_ready: got %b want 10", req_ready);
    end
    step();  // cycle 1
    req_valid = 2'b00;
    for (int c = 2; c <= 4; c++) begin
      step();
      checks++;
      if (penable !== 1'b1 || paddr !== 32'h20 || pwrite !== 1'b0 || rsp_valid !== 2'b00) begin
        errors++;
        $display("FAIL rd_wait_c%0d: penable=%b paddr=%h pwrite=%b rsp_valid=%b",
                 c, penable, paddr, pwrite, rsp_valid);
      end
    end
    step();  // cycle 5: 4th ACCESS cycle
    pready = 1'b1;
    prdata = 32'hDEAD_BEEF;
    step();  // cycle 6
    pready = 1'b0;
    prdata = '0;
    checks++;
    if (rsp_valid !== 2'b10 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rd_rsp: rsp_valid=%b rdata=%h err=%b, want 10/deadbeef/0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    step();
  endtask

  task automatic test_contention();
    logic [1:0] ready_exp;
    logic [1:0] rsp_exp;
    logic [31:0] addr_exp;
    logic [31:0] rd_exp;
    int g;
    int n;
    pready = 1'b1;
    req_valid = 2'b11;
    req_write = 2'b01;  // requester 0 writes, requester 1 reads
    req_addr[31:0] = 32'h100;
    req_addr[63:32] = 32'h200;
    #1;
    for (int k = 0; k < 8; k++) begin
      g = k % 2;
      n = k / 2;
      ready_exp = (g == 0) ? 2'b01 : 2'b10;
      addr_exp = (g == 0) ? (32'h100 + 32'(n * 4)) : (32'h200 + 32'(n * 4));
      rd_exp = (g == 0) ? 32'h0 : (32'hC0DE_0000 + 32'(k));
      checks++;
      if (req_ready !== ready_exp || psel !== 1'b0) begin
        errors++;
        $display("FAIL cont_grant_%0d: ready=%b psel=%b, want %b/0", k, req_ready, psel, ready_exp);
      end
      step();  // SETUP: move the granted requester to its next command
      if (g == 0) begin
        req_addr[31:0] = 32'h100 + 32'((n + 1) * 4);
        if (n == 3) req_valid[0] = 1'b0;
      end else begin
        req_addr[63:32] = 32'h200 + 32'((n + 1) * 4);
        if (n == 3) req_valid[1] = 1'b0;
      end
      checks++;
      if (psel !== 1'b1 || penable !== 1'b0 || paddr !== addr_exp) begin
        errors++;
        $display("FAIL cont_setup_%0d: psel=%b penable=%b paddr=%h want %h",
                 k, psel, penable, paddr, addr_exp);
      end
      step();  // ACCESS
      prdata = 32'hC0DE_0000 + 32'(k);
      step();  // response cycle, also the next idle cycle
      rsp_exp = ready_exp;
      checks++;
      if (rsp_valid !== rsp_exp || rsp_rdata !== rd_exp || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL cont_rsp_%0d: rsp_valid=%b rdata=%h err=%b, want %b/%h/0",
                 k, rsp_valid, rsp_rdata, rsp_err, rsp_exp, rd_exp);
      end
    end
    checks++;
    if (req_ready !== 2'b00 || psel !== 1'b0) begin
      errors++;
      $display("FAIL cont_end: ready=%b psel=%b, want 00/0", req_ready, psel);
    end
    step();
  endtask

  task automatic test_timeout();
    int c;
    int access_cycles;
    pready = 1'b0;
    req_valid = 2'b01;
    req_write = 2'b00;
    req_addr[31:0] = 32'h30;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL to_ready: got %b want 01", req_ready);
    end
    step();  // cycle 1
    req_valid = 2'b00;
    step();  // cycle 2
    c = 2;
    access_cycles = 0;
    while (penable === 1'b1 && c < 40) begin
      access_cycles++;
      step();
      c++;
    end
    checks++;
    if (access_cycles != 16 || c != TO + 2) begin
      errors++;
      $display("FAIL to_length: access_cycles=%0d rsp_cycle=%0d, want 16/18", access_cycles, c);
    end
    checks++;
    if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== '0) begin
      errors++;
      $display("FAIL to_rsp: rsp_valid=%b err=%b rdata=%h, want 01/1/0",
               rsp_valid, rsp_err, rsp_rdata);
    end
    step();
    // The next transfer must run normally.
    pready = 1'b1;
    req_valid = 2'b10;
    req_write = 2'b10;
    req_addr[63:32] = 32'h40;
    req_wdata[63:32] = 32'h1111_2222;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL to_next_ready: got %b want 10", req_ready);
    end
    step();
    req_valid = 2'b00;
    step();
    step();
    checks++;
    if (rsp_valid !== 2'b10 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL to_next_rsp: rsp_valid=%b err=%b, want 10/0", rsp_valid, rsp_err);
    end
    step();
  endtask

  task automatic test_reset_mid();
    pready = 1'b0;
    req_valid = 2'b01;
    req_write = 2'b01;
    req_addr[31:0] = 32'h50;
    req_wdata[31:0] = 32'h5555_AAAA;
    #1;
    step();  // cycle 1
    req_valid = 2'b00;
    step();  // cycle 2: 1st ACCESS
    step();  // cycle 3: 2nd ACCESS
    checks++;
    if (penable !== 1'b1 || paddr !== 32'h50) begin
      errors++;
      $display("FAIL rst_pre: penable=%b paddr=%h, want 1/50", penable, paddr);
    end
    preset = 1'b1;
    #1;
    checks++;
    if ({psel, penable, pwrite, rsp_err} !== 4'b0000 || paddr !== '0 || pwdata !== '0 ||
        rsp_valid !== '0 || rsp_rdata !== '0) begin
      errors++;
      $display("FAIL rst_mid: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h rsp_valid=%b",
               psel, penable, pwrite, paddr, pwdata, rsp_valid);
    end
    pready = 1'b1;
    step();
    step();
    preset = 1'b0;
    checks++;
    if (rsp_valid !== 2'b00 || psel !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_rsp: rsp_valid=%b psel=%b, want 00/0", rsp_valid, psel);
    end
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr[63:32] = 32'h60;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rst_first_grant: got %b want 01", req_ready);
    end
    step();
    req_valid = 2'b10;
    checks++;
    if (psel !== 1'b1 || paddr !== 32'h50) begin
      errors++;
      $display("FAIL rst_setup: psel=%b paddr=%h, want 1/50", psel, paddr);
    end
    step();
    step();
    checks++;
    if (rsp_valid !== 2'b01 || req_ready !== 2'b10) begin
      errors++;
      $display("FAIL rst_resume: rsp_valid=%b ready=%b, want 01/10", rsp_valid, req_ready);
    end
    step();
    req_valid = 2'b00;
    step();
    step();
    checks++;
    if (rsp_valid !== 2'b10) begin
      errors++;
      $display("FAIL rst_second: rsp_valid=%b want 10", rsp_valid);
    end
  endtask

  initial begin
    preset    = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    prdata    = '0;
    pready    = 1'b0;
    test_reset();
    test_single_write();
    test_read_wait();
    test_contention();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
